// File: rtl/tune_recorder.sv
// Records debounced key codes as (code, duration) events and replays them on demand.
// When neither recording nor playing, key codes pass through with one cycle of latency.
module tune_recorder #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned DUR_MAX  = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [3:0]               button_in,
  input  logic                     record,
  input  logic                     play,
  output logic [3:0]               button_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     recording,
  output logic                     playing,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    PLAY
  } state_t;

  state_t          state;
  logic            record_q;
  logic            play_q;
  logic [31:0]     tick;
  logic [7:0]      dur;
  logic [3:0]      cur_code;
  logic [AW-1:0]   idx;

  logic [3:0]      mem_code [DEPTH];
  logic [7:0]      mem_dur  [DEPTH];

  logic            rec_rise;
  logic            rec_fall;
  logic            play_rise;
  logic            tick_wrap;
  logic [7:0]      dur_next;
  logic            rec_close;
  logic [7:0]      wr_dur;
  logic [AW-1:0]   waddr;
  logic [CW-1:0]   count_inc;
  logic [AW-1:0]   idx_nxt;
  logic            idx_last;
  logic            note_done;

  // dur_next already includes a wrap happening on this edge, so closing and
  // note-advance decisions see floor(elapsed / TICK_DIV) exactly.
  always_comb begin
    rec_rise  = record & ~record_q;
    rec_fall  = ~record & record_q;
    play_rise = play & ~play_q;
    tick_wrap = (tick == 32'(TICK_DIV - 1));
    dur_next  = tick_wrap ? dur + 8'd1 : dur;
    rec_close = (state == REC) &&
                ((button_in != cur_code) || (dur_next == 8'(DUR_MAX)) || rec_fall);
    wr_dur    = (dur_next == '0) ? 8'd1 : dur_next;
    waddr     = count[AW-1:0];
    count_inc = count + 1'b1;
    idx_nxt   = idx + 1'b1;
    idx_last  = (CW'(idx) == count - 1'b1);
    note_done = (dur_next == mem_dur[idx]);
  end

  // Event memory is deliberately not reset; count qualifies its contents.
  always_ff @(posedge clk) begin
    if (rec_close) begin
      mem_code[waddr] <= cur_code;
      mem_dur[waddr]  <= wr_dur;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      button_out <= '0;
      count      <= '0;
      recording  <= 1'b0;
      playing    <= 1'b0;
      full       <= 1'b0;
      record_q   <= 1'b0;
      play_q     <= 1'b0;
      tick       <= '0;
      dur        <= '0;
      cur_code   <= '0;
      idx        <= '0;
    end else begin
      record_q <= record;
      play_q   <= play;
      case (state)
        IDLE: begin
          button_out <= button_in;
          if (rec_rise) begin
            count     <= '0;
            full      <= 1'b0;
            cur_code  <= button_in;
            tick      <= '0;
            dur       <= '0;
            recording <= 1'b1;
            state     <= REC;
          end else if (play_rise && (count != '0)) begin
            idx        <= '0;
            button_out <= mem_code[0];
            tick       <= '0;
            dur        <= '0;
            playing    <= 1'b1;
            state      <= PLAY;
          end
        end

        REC: begin
          button_out <= button_in;
          if (rec_close) begin
            count    <= count_inc;
            cur_code <= button_in;
            tick     <= '0;
            dur      <= '0;
            if (count_inc == CW'(DEPTH)) begin
              full      <= 1'b1;
              recording <= 1'b0;
              state     <= IDLE;
            end else if (rec_fall) begin
              recording <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            tick <= tick_wrap ? '0 : tick + 32'd1;
            dur  <= dur_next;
          end
        end

        PLAY: begin
          if (play_rise) begin
            button_out <= '0;
            playing    <= 1'b0;
            state      <= IDLE;
          end else if (note_done) begin
            tick <= '0;
            dur  <= '0;
            if (idx_last) begin
              button_out <= '0;
              playing    <= 1'b0;
              state      <= IDLE;
            end else begin
              idx        <= idx_nxt;
              button_out <= mem_code[idx_nxt];
            end
          end else begin
            tick <= tick_wrap ? '0 : tick + 32'd1;
            dur  <= dur_next;
          end
        end

        default: begin
          button_out <= '0;
          recording  <= 1'b0;
          playing    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tune_recorder.sv
// Directed bench for tune_recorder with TICK_DIV=4, DEPTH=4, DUR_MAX=3.
module tb_tune_recorder;

  logic       clk;
  logic       resetn;
  logic [3:0] button_in;
  logic       record;
  logic       play;
  logic [3:0] button_out;
  logic [2:0] count;
  logic       recording;
  logic       playing;
  logic       full;

  int checks;
  int failures;

  tune_recorder #(
    .DEPTH   (4),
    .TICK_DIV(4),
    .DUR_MAX (3)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .button_in (button_in),
    .record    (record),
    .play      (play),
    .button_out(button_out),
    .count     (count),
    .recording (recording),
    .playing   (playing),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    button_in = 4'd0;
    record    = 1'b0;
    play      = 1'b0;

    // reset state
    #12;
    chk("rst_button_out", 32'(button_out), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_recording", 32'(recording), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_full", 32'(full), 0);
    resetn = 1'b1;
    step(2);

    // pass-through with one cycle latency
    button_in = 4'd5;
    chk("pt_before", 32'(button_out), 0);
    step(1);
    chk("pt_after", 32'(button_out), 5);
    chk("pt_count", 32'(count), 0);
    chk("pt_recording", 32'(recording), 0);
    chk("pt_playing", 32'(playing), 0);
    button_in = 4'd0;
    step(1);

    // record 1 for 12 cycles, 3 for 8 cycles
    record    = 1'b1;
    button_in = 4'd1;
    step(1);
    chk("rec_flag", 32'(recording), 1);
    chk("rec_pass", 32'(button_out), 1);
    step(11);
    chk("rec_cnt0", 32'(count), 0);
    button_in = 4'd3;
    step(1);
    chk("rec_cnt1", 32'(count), 1);
    chk("rec_pass3", 32'(button_out), 3);
    step(7);
    record = 1'b0;
    step(1);
    chk("rec_cnt2", 32'(count), 2);
    chk("rec_stop", 32'(recording), 0);
    button_in = 4'd0;
    step(1);
    chk("rec_idle_pass", 32'(button_out), 0);

    // play back: 1 for 12 cycles, 3 for 8 cycles, then 0
    play = 1'b1;
    step(1);
    play = 1'b0;
    chk("play_flag", 32'(playing), 1);
    chk("play_n0_first", 32'(button_out), 1);
    for (int k = 1; k < 12; k++) begin
      step(1);
      chk("play_n0_hold", 32'(button_out), 1);
    end
    step(1);
    chk("play_n1_first", 32'(button_out), 3);
    for (int k = 1; k < 8; k++) begin
      step(1);
      chk("play_n1_hold", 32'(button_out), 3);
      chk("play_flag_hold", 32'(playing), 1);
    end
    step(1);
    chk("play_end_out", 32'(button_out), 0);
    chk("play_end_flag", 32'(playing), 0);

    // short press of 7, then 2 held 20 cycles (saturates at 3 ticks)
    record    = 1'b1;
    button_in = 4'd7;
    step(1);
    chk("sat_cnt_clear", 32'(count), 0);
    step(1);
    button_in = 4'd2;
    step(1);
    chk("sat_short_cnt", 32'(count), 1);
    step(11);
    chk("sat_pre_cnt", 32'(count), 1);
    step(1);
    chk("sat_split_cnt", 32'(count), 2);
    step(7);
    record = 1'b0;
    step(1);
    chk("sat_final_cnt", 32'(count), 3);
    chk("sat_rec_off", 32'(recording), 0);
    button_in = 4'd0;
    step(1);

    // expected playback: 7 x4 cycles, 2 x12, 2 x8
    play = 1'b1;
    step(1);
    play = 1'b0;
    chk("sat_p0", 32'(button_out), 7);
    step(3);
    chk("sat_p3", 32'(button_out), 7);
    step(1);
    chk("sat_p4", 32'(button_out), 2);
    step(19);
    chk("sat_p23", 32'(button_out), 2);
    chk("sat_p23_flag", 32'(playing), 1);
    step(1);
    chk("sat_p24", 32'(button_out), 0);
    chk("sat_p24_flag", 32'(playing), 0);
    step(1);

    // abort with a second play pulse
    play = 1'b1;
    step(1);
    play = 1'b0;
    step(5);
    chk("abort_mid", 32'(button_out), 2);
    play = 1'b1;
    step(1);
    play = 1'b0;
    chk("abort_out", 32'(button_out), 0);
    chk("abort_flag", 32'(playing), 0);
    step(2);
    chk("abort_idle", 32'(playing), 0);

    // record and play rising together: record wins
    record = 1'b1;
    play   = 1'b1;
    step(1);
    chk("conflict_rec", 32'(recording), 1);
    chk("conflict_play", 32'(playing), 0);
    record = 1'b0;
    play   = 1'b0;
    step(1);
    chk("conflict_cnt", 32'(count), 1);
    chk("conflict_stop", 32'(recording), 0);
    step(1);

    // fill memory: five codes, 8 cycles each
    record    = 1'b1;
    button_in = 4'd1;
    step(1);
    step(7);
    button_in = 4'd2;
    step(8);
    button_in = 4'd3;
    step(8);
    button_in = 4'd4;
    step(8);
    chk("full_pre_cnt", 32'(count), 3);
    chk("full_pre_rec", 32'(recording), 1);
    chk("full_pre_flag", 32'(full), 0);
    button_in = 4'd5;
    step(1);
    chk("full_cnt", 32'(count), 4);
    chk("full_flag", 32'(full), 1);
    chk("full_rec_off", 32'(recording), 0);
    chk("full_pass5", 32'(button_out), 5);
    step(8);
    chk("full_cnt_hold", 32'(count), 4);
    chk("full_pass_hold", 32'(button_out), 5);
    record    = 1'b0;
    button_in = 4'd0;
    step(2);
    chk("full_rec_fall_idle", 32'(recording), 0);

    play = 1'b1;
    step(1);
    play = 1'b0;
    chk("full_p0", 32'(button_out), 1);
    step(7);
    chk("full_p7", 32'(button_out), 1);
    step(1);
    chk("full_p8", 32'(button_out), 2);
    step(8);
    chk("full_p16", 32'(button_out), 3);
    step(8);
    chk("full_p24", 32'(button_out), 4);
    step(7);
    chk("full_p31", 32'(button_out), 4);
    step(1);
    chk("full_p32", 32'(button_out), 0);
    chk("full_p32_flag", 32'(playing), 0);
    step(1);

    // asynchronous reset in the middle of playback
    play = 1'b1;
    step(1);
    play = 1'b0;
    chk("areset_playing", 32'(playing), 1);
    step(3);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_out", 32'(button_out), 0);
    chk("areset_flag", 32'(playing), 0);
    chk("areset_cnt", 32'(count), 0);
    @(negedge clk);
    resetn = 1'b1;
    step(1);

    // play with empty memory is ignored
    button_in = 4'd6;
    play      = 1'b1;
    step(1);
    play = 1'b0;
    chk("empty_play_flag", 32'(playing), 0);
    chk("empty_play_pass", 32'(button_out), 6);
    chk("empty_play_cnt", 32'(count), 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tune_recorder.md
# tune_recorder

Records the stream of debounced key codes produced by the keypad scanner as (note, duration) events and replays them on demand. It sits between the keypad debouncer's 4-bit `button` output and the tone-data lookup. Its `button_out` replaces the raw key code as the tone-data input. When neither recording nor playing, it passes key codes straight through with one cycle of latency.

## Interface
- `DEPTH`, 16: number of stored events (power of two, 2..64).
- `TICK_DIV`, 5000000: clock cycles per duration tick (100 ms at 50 MHz).
- `DUR_MAX`, 255: saturation value of the per-event tick count (8-bit field).

- `clk`  in  1: system clock (50 MHz on board).
- `resetn`  in  1: reset, asynchronous assert, active-low.
- `button_in`  in  4: key code from the debouncer; 0 = no note / silence.
- `record`  in  1: record switch, synchronous level; the rising edge starts recording, the falling edge stops it.
- `play`  in  1: play button, synchronous level; the rising edge starts or aborts playback.
- `button_out`  out  4: code to the tone-data stage.
- `count`  out  $clog2(DEPTH)+1: number of stored events.
- `recording`  out  1: high in state REC.
- `playing`  out  1: high in state PLAY.
- `full`  out  1: the last recording stopped because memory filled.

## Operation
- **Storage and edge detection**
  - Event memory holds DEPTH entries of {code[3:0], dur[7:0]}. The memory is not reset; `count` gates its validity.
  - `record_q` and `play_q` are registered copies used for edge detection.
- **States.** IDLE, REC, PLAY, one-hot or encoded; the default branch goes to IDLE.
- **IDLE**
  - `button_out` <= `button_in`.
  - Record rising: `count` <= 0, `full` <= 0, `cur_code` <= `button_in`, tick and duration counters <= 0, go to REC.
  - Play rising with `count` > 0: index <= 0, `button_out` <= mem[0].code, counters <= 0, go to PLAY.
  - Play rising with `count` == 0: ignored.
  - Record rising and play rising in the same cycle: record wins.
- **REC**
  - `button_out` <= `button_in` (the user hears what is played).
  - The tick counter counts 0..TICK_DIV-1. On wrap, `dur` increments.
  - Event close: triggered when `button_in` != `cur_code`, or `dur` reaches DUR_MAX.
    - Write {`cur_code`, max(`dur`,1)} at index `count`, then `count`++.
    - `cur_code` <= `button_in`; counters <= 0.
  - Saturated events simply continue as a new event with the same code.
  - Silence (code 0) is recorded as an event like any note.
  - Record falling: close the current event the same way, then go to IDLE.
  - If a write makes `count` == DEPTH: `full` <= 1 and go to IDLE immediately. The write that fills the memory is kept; further input is not recorded.
  - Play edges in REC are ignored.
- **PLAY**
  - `button_out` holds mem[index].code.
  - The tick counter wraps at TICK_DIV and increments `dur`.
  - When `dur` == mem[index].dur:
    - If index == `count`-1: `button_out` <= 0, go to IDLE.
    - Else index++, `button_out` <= mem[index+1].code, counters <= 0.
  - Play rising in PLAY: abort, `button_out` <= 0, go to IDLE.
  - Record edges in PLAY are ignored; `record_q` still tracks the input, so a switch already high at the end of playback does not start recording.
- **Widths**
  - Tick counter: 32-bit, unsigned compare against TICK_DIV-1.
  - `dur`: 8-bit, never exceeds DUR_MAX.
  - index: $clog2(DEPTH) bits.

## Timing
- **Reset values:** state IDLE, `button_out` 0, `count` 0, `recording` 0, `playing` 0, `full` 0, `record_q` 0, `play_q` 0, all counters 0.
- **Reset mid-operation** aborts immediately and clears `count`, losing the recording.
- **Pass-through latency:** `button_in` at edge N appears on `button_out` after edge N, in IDLE and REC.
- **Flags:** `recording` and `playing` are registered and change on the same edge as the state.
- **Playback duration:** each entry lasts exactly dur × TICK_DIV cycles. The first note appears on the edge that samples the play rising edge.
- **Recorded duration:** floor(elapsed cycles / TICK_DIV), minimum 1.
- **Write timing:** the write occurs on the same edge that detects the close condition. The new event's counters start from 0 on that edge.

## Test plan
All scenarios use TICK_DIV=4 and DEPTH=4.

1. **Pass-through:** `button_in`=5 at cycle 10 -> `button_out`=5 at cycle 11; `count` stays 0, flags stay 0.
2. **Record and play:**
   - Stimulus: record up; `button_in`=1 for 12 cycles, then 3 for 8 cycles; record down.
   - Expect `count`=2 with mem = {1,3},{3,2}.
   - Play pulse -> `button_out`=1 for 12 cycles, then 3 for 8 cycles, then 0; `playing` falls on the same edge.
3. **Short press and saturation:**
   - A 2-cycle press of 7 is stored with dur=1.
   - With DUR_MAX forced to 3, holding 2 for 20 cycles yields events {2,3},{2,2}.
4. **Full:** five distinct codes, each held 8 cycles, with record held -> `count`=4, `full`=1, `recording`=0 after the 4th write. The fifth code is passed through but not stored.
5. **Abort and conflicts:**
   - A second play pulse mid-playback -> `button_out`=0 on the next edge, state IDLE.
   - Record rising and play rising in the same IDLE cycle -> REC.
   - Play with `count`=0 -> no change.
6. **Async reset:** resetn low mid-PLAY, between clock edges -> `button_out`=0, `playing`=0, `count`=0 immediately, without waiting for a clock edge.
